store_write_buffer: RTL and testbench
=====================================

# store_write_buffer

Post-commit write buffer between the store queue's retire port and the data-memory write port. It accepts one committed store per cycle and converts func3/addr into a word-aligned byte-enable and lane-replicated data. Entries are held in an in-order FIFO until the memory accepts them through a valid/ready handshake. While they wait, they forward store data to younger loads, because a store drained from the store queue is otherwise invisible until memory is written.

## Interface
- WB_DEPTH, 4, number of buffer entries (power of two, ≥2)
- WB_WIDTH, 2, log2(WB_DEPTH)
- clk  input  1  clock
- reset_n  input  1  reset, synchronous, active-low
- in_valid  input  1  committed store from store queue (its retire_sq2mem_valid)
- in_addr  input  32  store byte address
- in_data  input  32  store data, right-aligned
- in_func3  input  3  000 SB, 001 SH, 010 SW
- in_ready  output  1  buffer can take a store this cycle; gates store-queue dequeue
- mem_wr_valid  output  1  head entry presented to memory
- mem_wr_ready  input  1  memory accepts head entry
- mem_wr_addr  output  32  {addr[31:2],2'b00}
- mem_wr_be  output  4  byte enables
- mem_wr_data  output  32  lane-replicated data
- fwd_addr  input  32  load byte address
- fwd_hit  output  1  at least one byte of the load's word is buffered
- fwd_be  output  4  buffered byte lanes of that word
- fwd_data  output  32  merged buffered bytes (lanes not in fwd_be are 0)
- wb_empty  output  1  no entries; used by fence/drain logic
- st_err  output  1  one-cycle pulse, illegal or misaligned store dropped
- st_err_addr  output  32  address of the dropped store, held until the next error

## Operation
- **Storage:** circular FIFO with head/tail pointers of WB_WIDTH bits and a count of WB_WIDTH+1 bits. Each entry holds word addr[31:2], be[3:0] and data[31:0].
- **Ready:** in_ready = (count != WB_DEPTH), computed from the registered count only. There is no path from mem_wr_ready to in_ready.
- **Push:** when in_valid & in_ready, write the entry at tail and advance tail (wraps modulo WB_DEPTH). If in_valid is high while in_ready is low, the input is ignored; preventing this is the upstream's responsibility.
- **Formatting of legal stores:**
  - SB: be = 4'b0001 << addr[1:0]; data = {4{in_data[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; data = {2{in_data[15:0]}}.
  - SW: be = 4'b1111; data = in_data.
- **Illegal stores:** SH with addr[0]=1, SW with addr[1:0]≠0, or func3 not in {000,001,010}. The store is not enqueued. st_err pulses the next cycle and st_err_addr latches in_addr. in_ready is unaffected.
- **Pop:** mem_wr_valid = (count != 0). mem_wr_addr, mem_wr_be and mem_wr_data come from the head entry and stay stable until mem_wr_ready is seen. On mem_wr_valid & mem_wr_ready, head advances and wraps.
- **Count update:** push and pop in the same cycle leave count unchanged. Push only: count+1. Pop only: count-1.
- **Forwarding (combinational):**
  - Scan all valid entries whose word address equals fwd_addr[31:2].
  - For each byte lane, take the data from the youngest matching entry whose be covers that lane.
  - fwd_be is the OR of the matching be values; fwd_hit = |fwd_be.
  - An entry being popped this cycle still forwards.
  - Same-cycle pushes do not forward; the store queue still holds that store.
- **Flush:** no flush input. Buffer contents are architecturally committed and always drain.
- **wb_empty** = (count == 0).

## Timing
- **Reset:** count=0, head=tail=0, all entries invalid, st_err=0, st_err_addr=0. Outputs during and after reset: mem_wr_valid=0, fwd_hit=0, fwd_be=0, fwd_data=0, wb_empty=1, in_ready=1.
- **Reset mid-operation:** all buffered stores are discarded with no memory write. Any in-progress mem_wr_valid drops in the cycle after reset is sampled.
- **Latency:** a store pushed in cycle N gives mem_wr_valid in cycle N+1 at the earliest. There is no input-to-memory bypass.
- **Throughput:** one push and one pop per cycle sustained.
- **Full with simultaneous pop:** in_ready stays 0 in that cycle and rises in the next cycle.
- **Forward visibility:** fwd_* reflect buffer state at the start of the cycle.
- **st_err:** a single-cycle pulse. Back-to-back illegal stores give back-to-back pulses, with st_err_addr updated each time.

## Test plan
- **Single store, memory ready:** SB addr=0x1003, data=0xAB, mem_wr_ready=1. Expect in cycle N+1: mem_wr_addr=0x1000, be=4'b1000, data=0xABABABAB. Expect wb_empty=1 in cycle N+2.
- **Fill and wrap:** hold mem_wr_ready=0 and push 4 SW stores. Expect in_ready=0 after the 4th push. Raise mem_wr_ready for one cycle with in_valid=1. Expect in_ready=0 in that cycle and 1 in the next. Continue pushes across the pointer wrap and check that memory sees the stores in exact FIFO order.
- **Forward merge:** buffer SW 0x2000=0x11223344, then SB 0x2001=0xEE. fwd_addr=0x2002 gives fwd_hit=1, be=4'b1111, data=0x1122EE44. fwd_addr=0x2004 gives fwd_hit=0.
- **Partial coverage:** buffer only SH 0x3002=0xBEEF. fwd_addr=0x3000 gives be=4'b1100, data=0xBEEF0000.
- **Illegal stores:** SW addr=0x4002, then SH addr=0x4001, then func3=3'b011. Expect three st_err pulses with st_err_addr=0x4002, 0x4001, 0x4000 in turn. Expect count unchanged and no memory write.
- **Reset with 3 entries pending:** expect mem_wr_valid=0, wb_empty=1, in_ready=1 in the cycle after reset. No further memory writes occur.

Source files
------------

// File: rtl/store_write_buffer.sv
// Post-commit store write buffer: formats committed stores into word/be/data and drains them in order to memory.
// Latency: a store pushed in cycle N is visible on mem_wr_* in N+1; forwarding reads the registered contents.
// Backpressure: in_ready drops only when full (registered count); the head stays stable until mem_wr_ready.
module store_write_buffer #(
    parameter int WB_DEPTH = 4,
    parameter int WB_WIDTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic [2:0]  in_func3,
    output logic        in_ready,
    output logic        mem_wr_valid,
    input  logic        mem_wr_ready,
    output logic [31:0] mem_wr_addr,
    output logic [3:0]  mem_wr_be,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] fwd_addr,
    output logic        fwd_hit,
    output logic [3:0]  fwd_be,
    output logic [31:0] fwd_data,
    output logic        wb_empty,
    output logic        st_err,
    output logic [31:0] st_err_addr
);

    typedef struct packed {
        logic [29:0] waddr;
        logic [3:0]  be;
        logic [31:0] data;
    } wb_entry_t;

    localparam logic [WB_WIDTH:0] FULL_CNT = (WB_WIDTH + 1)'(WB_DEPTH);

    wb_entry_t           ent_q [WB_DEPTH];
    wb_entry_t           ent_d [WB_DEPTH];
    logic [WB_WIDTH-1:0] head_q, head_d;
    logic [WB_WIDTH-1:0] tail_q, tail_d;
    logic [WB_WIDTH:0]   count_q, count_d;
    logic                st_err_q, st_err_d;
    logic [31:0]         st_err_addr_q, st_err_addr_d;

    logic                fmt_legal;
    logic [3:0]          fmt_be;
    logic [31:0]         fmt_data;
    logic                push, pop;
    logic [WB_WIDTH-1:0] fwd_idx;

    always_comb begin
        fmt_legal = 1'b0;
        fmt_be    = 4'b0000;
        fmt_data  = in_data;
        case (in_func3)
            3'b000: begin
                fmt_legal = 1'b1;
                fmt_be    = 4'b0001 << in_addr[1:0];
                fmt_data  = {4{in_data[7:0]}};
            end
            3'b001: begin
                fmt_legal = ~in_addr[0];
                fmt_be    = in_addr[1] ? 4'b1100 : 4'b0011;
                fmt_data  = {2{in_data[15:0]}};
            end
            3'b010: begin
                fmt_legal = (in_addr[1:0] == 2'b00);
                fmt_be    = 4'b1111;
            end
            default: fmt_legal = 1'b0;
        endcase
    end

    assign in_ready     = (count_q != FULL_CNT);
    assign mem_wr_valid = (count_q != '0);
    assign wb_empty     = (count_q == '0);
    assign push         = in_valid & in_ready & fmt_legal;
    assign pop          = mem_wr_valid & mem_wr_ready;

    assign mem_wr_addr  = {ent_q[head_q].waddr, 2'b00};
    assign mem_wr_be    = ent_q[head_q].be;
    assign mem_wr_data  = ent_q[head_q].data;
    assign st_err       = st_err_q;
    assign st_err_addr  = st_err_addr_q;

    always_comb begin
        ent_d         = ent_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        st_err_d      = in_valid & in_ready & ~fmt_legal;
        st_err_addr_d = st_err_d ? in_addr : st_err_addr_q;
        if (push) begin
            ent_d[tail_q] = '{waddr: in_addr[31:2], be: fmt_be, data: fmt_data};
            tail_d        = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < WB_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            st_err_q      <= 1'b0;
            st_err_addr_q <= '0;
        end else begin
            ent_q         <= ent_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            st_err_q      <= st_err_d;
            st_err_addr_q <= st_err_addr_d;
        end
    end

    // Walk oldest to youngest so later matches overwrite lanes: youngest store wins per byte.
    always_comb begin
        fwd_be   = 4'b0000;
        fwd_data = '0;
        fwd_idx  = head_q;
        for (int k = 0; k < WB_DEPTH; k++) begin
            fwd_idx = head_q + WB_WIDTH'(k);
            if (((WB_WIDTH + 1)'(k) < count_q) && (ent_q[fwd_idx].waddr == fwd_addr[31:2])) begin
                fwd_be = fwd_be | ent_q[fwd_idx].be;
                for (int l = 0; l < 4; l++) begin
                    if (ent_q[fwd_idx].be[l]) begin
                        fwd_data[8*l +: 8] = ent_q[fwd_idx].data[8*l +: 8];
                    end
                end
            end
        end
    end

    assign fwd_hit = |fwd_be;

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed scenarios plus random traffic, all cycles checked against a queue model.
module tb_store_write_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_data = '0;
    logic [2:0]  in_func3 = '0;
    logic        in_ready;
    logic        mem_wr_valid;
    logic        mem_wr_ready = 1'b0;
    logic [31:0] mem_wr_addr;
    logic [3:0]  mem_wr_be;
    logic [31:0] mem_wr_data;
    logic [31:0] fwd_addr = '0;
    logic        fwd_hit;
    logic [3:0]  fwd_be;
    logic [31:0] fwd_data;
    logic        wb_empty;
    logic        st_err;
    logic [31:0] st_err_addr;

    always #5 clk = ~clk;

    store_write_buffer #(.WB_DEPTH(4), .WB_WIDTH(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_func3(in_func3),
        .in_ready(in_ready),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_be(mem_wr_be), .mem_wr_data(mem_wr_data),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_be(fwd_be), .fwd_data(fwd_data),
        .wb_empty(wb_empty), .st_err(st_err), .st_err_addr(st_err_addr)
    );

    typedef struct {
        logic [29:0] w;
        logic [3:0]  be;
        logic [31:0] d;
    } ment_t;

    ment_t       mq[$];
    logic        exp_err = 1'b0;
    logic [31:0] exp_err_addr = '0;
    int          checks = 0;
    int          failures = 0;
    bit          checking = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Size in bytes is 1<<func3; a store is legal when it fits naturally aligned in its word.
    function automatic void fmt(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                                output bit legal, output logic [3:0] be, output logic [31:0] data);
        int sz, off;
        be = '0;
        data = '0;
        legal = 0;
        if (f <= 3'd2) begin
            sz = 1 << f;
            off = int'(a[1:0]);
            legal = (off % sz) == 0;
            if (legal) begin
                for (int j = 0; j < 4; j++) begin
                    if (j >= off && j < off + sz) be[j] = 1'b1;
                    data[8*j +: 8] = d[8*(j % sz) +: 8];
                end
            end
        end
    endfunction

    function automatic void model_fwd(input logic [31:0] fa, output logic [3:0] be, output logic [31:0] dt);
        be = '0;
        dt = '0;
        for (int l = 0; l < 4; l++) begin
            for (int e = mq.size() - 1; e >= 0; e--) begin
                if (mq[e].w == fa[31:2] && mq[e].be[l]) begin
                    be[l] = 1'b1;
                    dt[8*l +: 8] = mq[e].d[8*l +: 8];
                    break;
                end
            end
        end
    endfunction

    task automatic check_all();
        logic [3:0]  ebe;
        logic [31:0] edt;
        chk("in_ready", in_ready, mq.size() != DEPTH);
        chk("mem_wr_valid", mem_wr_valid, mq.size() != 0);
        chk("wb_empty", wb_empty, mq.size() == 0);
        if (mq.size() != 0) begin
            chk("mem_wr_addr", mem_wr_addr, {mq[0].w, 2'b00});
            chk("mem_wr_be", mem_wr_be, mq[0].be);
            chk("mem_wr_data", mem_wr_data, mq[0].d);
        end
        model_fwd(fwd_addr, ebe, edt);
        chk("fwd_be", fwd_be, ebe);
        chk("fwd_hit", fwd_hit, |ebe);
        chk("fwd_data", fwd_data, edt);
        chk("st_err", st_err, exp_err);
        chk("st_err_addr", st_err_addr, exp_err_addr);
    endtask

    task automatic update();
        bit          rdy, legal;
        logic [3:0]  be;
        logic [31:0] dt;
        if (!reset_n) begin
            mq.delete();
            exp_err = 1'b0;
            exp_err_addr = '0;
        end else begin
            rdy = mq.size() != DEPTH;
            fmt(in_func3, in_addr, in_data, legal, be, dt);
            if (mq.size() != 0 && mem_wr_ready) void'(mq.pop_front());
            if (in_valid && rdy && legal) mq.push_back('{w: in_addr[31:2], be: be, d: dt});
            exp_err = in_valid && rdy && !legal;
            if (exp_err) exp_err_addr = in_addr;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (checking) check_all();
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        in_valid = v;
        in_func3 = f;
        in_addr = a;
        in_data = d;
    endtask

    initial begin
        drive(0, 3'b000, 32'h0, 32'h0);
        cycle();
        checking = 1;
        cycle();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wb_empty", wb_empty, 1);
        chk("rst_mem_wr_valid", mem_wr_valid, 0);
        reset_n = 1'b1;
        cycle();

        // single SB with memory ready
        mem_wr_ready = 1'b1;
        drive(1, 3'b000, 32'h0000_1003, 32'h0000_00AB);
        cycle();
        drive(0, 3'b000, 32'h0, 32'h0);
        #1;
        chk("sb_valid", mem_wr_valid, 1);
        chk("sb_addr", mem_wr_addr, 32'h0000_1000);
        chk("sb_be", mem_wr_be, 4'b1000);
        chk("sb_data", mem_wr_data, 32'hABAB_ABAB);
        cycle();
        #1;
        chk("sb_empty_after", wb_empty, 1);

        // fill, pop-while-full, then wrap
        mem_wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 3'b010, 32'h0000_0100 + 32'(i * 4), $urandom);
            cycle();
        end
        #1;
        chk("full_in_ready", in_ready, 0);
        mem_wr_ready = 1'b1;
        drive(1, 3'b010, 32'h0000_0110, $urandom);
        #1;
        chk("full_pop_in_ready", in_ready, 0);
        cycle();
        #1;
        chk("after_pop_in_ready", in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            drive(1, 3'b010, 32'h0000_0200 + 32'(i * 4), $urandom);
            cycle();
        end
        drive(0, 3'b000, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) cycle();

        // forward merge
        mem_wr_ready = 1'b0;
        drive(1, 3'b010, 32'h0000_2000, 32'h1122_3344);
        cycle();
        drive(1, 3'b000, 32'h0000_2001, 32'h0000_00EE);
        cycle();
        drive(0, 3'b000, 32'h0, 32'h0);
        fwd_addr = 32'h0000_2002;
        #1;
        chk("merge_hit", fwd_hit, 1);
        chk("merge_be", fwd_be, 4'b1111);
        chk("merge_data", fwd_data, 32'h1122_EE44);
        fwd_addr = 32'h0000_2004;
        #1;
        chk("merge_miss_hit", fwd_hit, 0);
        cycle();
        mem_wr_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // partial coverage
        mem_wr_ready = 1'b0;
        drive(1, 3'b001, 32'h0000_3002, 32'h0000_BEEF);
        cycle();
        drive(0, 3'b000, 32'h0, 32'h0);
        fwd_addr = 32'h0000_3000;
        #1;
        chk("partial_be", fwd_be, 4'b1100);
        chk("partial_data", fwd_data, 32'hBEEF_0000);
        cycle();
        mem_wr_ready = 1'b1;
        for (int i = 0; i < 2; i++) cycle();

        // illegal stores, back to back
        drive(1, 3'b010, 32'h0000_4002, 32'h1234_5678);
        cycle();
        chk("err1", st_err, 1);
        chk("err1_addr", st_err_addr, 32'h0000_4002);
        drive(1, 3'b001, 32'h0000_4001, 32'h1234_5678);
        cycle();
        chk("err2", st_err, 1);
        chk("err2_addr", st_err_addr, 32'h0000_4001);
        drive(1, 3'b011, 32'h0000_4000, 32'h1234_5678);
        cycle();
        chk("err3", st_err, 1);
        chk("err3_addr", st_err_addr, 32'h0000_4000);
        chk("err_no_write", mem_wr_valid, 0);
        drive(0, 3'b000, 32'h0, 32'h0);
        cycle();
        chk("err_pulse_end", st_err, 0);
        chk("err_addr_held", st_err_addr, 32'h0000_4000);

        // random traffic on a small address window to provoke forwarding hits
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 4)),
                  32'h0000_5000 + 32'($urandom_range(0, 15)), $urandom);
            mem_wr_ready = (i < 400) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            fwd_addr = 32'h0000_5000 + 32'($urandom_range(0, 15));
            cycle();
        end
        drive(0, 3'b000, 32'h0, 32'h0);
        mem_wr_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();

        // reset with three entries pending
        mem_wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'b010, 32'h0000_6000 + 32'(i * 4), $urandom);
            cycle();
        end
        drive(0, 3'b000, 32'h0, 32'h0);
        chk("pre_rst_valid", mem_wr_valid, 1);
        reset_n = 1'b0;
        mem_wr_ready = 1'b1;
        cycle();
        reset_n = 1'b1;
        chk("post_rst_valid", mem_wr_valid, 0);
        chk("post_rst_empty", wb_empty, 1);
        chk("post_rst_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
